// File: rtl/gpr_file_bypass_if.sv
// Register-file access bundle: two read ports for ID, one write port from WB, plus the ready flag.
interface gpr_file_bypass_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              ready;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    modport master (
        input  ready, rs_data, rt_data,
        output rs_addr, rt_addr, we, waddr, wdata
    );

    modport slave (
        output ready, rs_data, rt_data,
        input  rs_addr, rt_addr, we, waddr, wdata
    );
endinterface

// File: rtl/gpr_file_bypass.sv
// Parametrised GPR file: two combinational read ports with write bypass, posedge write, sequential clear after reset.
// Optional simulation trace of accepted writes when GPR_TRACE_EN is defined.
module gpr_file_bypass #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic               clk,
    input  logic               rst,
    gpr_file_bypass_if.slave   bus
);
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        CLEAR = 2'b00,
        READY = 2'b01
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              is_ready;
    logic              wr_accept;

    function automatic logic [DATA_W-1:0] read_port(
        input logic              rdy,
        input logic [ADDR_W-1:0] addr,
        input logic              w_en,
        input logic [ADDR_W-1:0] w_addr,
        input logic [DATA_W-1:0] w_data,
        input logic [DATA_W-1:0] entry
    );
        if (!rdy)                           return '0;
        if (ZERO_REG != 0 && addr == '0)    return '0;
        if (w_en && w_addr == addr)         return w_data;
        return entry;
    endfunction

    assign is_ready  = (state_q == READY);
    // A write presented on the reset edge is dropped, as is any write to a hardwired entry 0.
    assign wr_accept = is_ready && !rst && bus.we &&
                       !(ZERO_REG != 0 && bus.waddr == '0);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == LAST_IDX) begin
                    state_d = READY;
                end
            end
            READY:   state_d = READY;
            default: begin
                state_d   = CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        if (!rst && state_q == CLEAR) begin
            regs_d[clr_cnt_q] = '0;
        end
        if (wr_accept) begin
            regs_d[bus.waddr] = bus.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Storage carries no reset; the clear sequencer zeroes it before ready.
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    always_comb begin
        bus.ready   = is_ready;
        bus.rs_data = read_port(is_ready, bus.rs_addr, bus.we, bus.waddr, bus.wdata,
                                regs_q[bus.rs_addr]);
        bus.rt_data = read_port(is_ready, bus.rt_addr, bus.we, bus.waddr, bus.wdata,
                                regs_q[bus.rt_addr]);
    end

`ifdef GPR_TRACE_EN
    always @(posedge clk) begin
        if (wr_accept) begin
            $display("GPR_WRITE: R[%02D]=%8X", bus.waddr, bus.wdata);
            for (int i = 0; i < NUM_REGS; i += 8) begin
                for (int j = i; j < i + 8 && j < NUM_REGS; j++) begin
                    $write("%8X ", regs_d[j]);
                end
                $display("");
            end
        end
    end
`else
`endif
endmodule

// File: tb/tb_gpr_file_bypass.sv
// Scoreboard bench: three register-file builds driven in lockstep against an abstract model.
module tb_gpr_file_bypass;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, rst2;

    gpr_file_bypass_if #(.DATA_W(32), .ADDR_W(5)) if0 ();
    gpr_file_bypass_if #(.DATA_W(32), .ADDR_W(5)) if1 ();
    gpr_file_bypass_if #(.DATA_W(64), .ADDR_W(3)) if2 ();

    gpr_file_bypass #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut0 (.clk(clk), .rst(rst0), .bus(if0));
    gpr_file_bypass #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut1 (.clk(clk), .rst(rst1), .bus(if1));
    gpr_file_bypass #(.DATA_W(64), .ADDR_W(3), .ZERO_REG(1)) dut2 (.clk(clk), .rst(rst2), .bus(if2));

    typedef struct {
        int          u;
        int          cyc;
        logic        ready;
        logic [63:0] rs;
        logic [63:0] rt;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   known    = 0;

    // Model: entries per unit, and count of non-reset edges since the last reset.
    logic [63:0] mem [3][32];
    int          cnt [3];
    int          nr  [3] = '{32, 32, 8};
    bit          zrf [3] = '{1'b1, 1'b0, 1'b1};
    logic [63:0] dmask [3] = '{64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};

    bit          s_rst   [3];
    bit          s_we    [3];
    logic [4:0]  s_waddr [3];
    logic [4:0]  s_rs    [3];
    logic [4:0]  s_rt    [3];
    logic [63:0] s_wdata [3];

    function automatic logic [63:0] model_rd(int u, logic [4:0] a);
        if (cnt[u] < nr[u])                   return 64'd0;
        if (zrf[u] && a == 5'd0)              return 64'd0;
        if (s_we[u] && s_waddr[u] == a)       return s_wdata[u] & dmask[u];
        return mem[u][a];
    endfunction

    task automatic chk(string nm, int u, int c, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s u%0d cyc%0d actual=%h expected=%h", nm, u, c, act, exp);
        end
    endtask

    task automatic cycle();
        rst0 = s_rst[0]; rst1 = s_rst[1]; rst2 = s_rst[2];
        if0.we = s_we[0]; if0.waddr = s_waddr[0]; if0.wdata = s_wdata[0][31:0];
        if0.rs_addr = s_rs[0]; if0.rt_addr = s_rt[0];
        if1.we = s_we[1]; if1.waddr = s_waddr[1]; if1.wdata = s_wdata[1][31:0];
        if1.rs_addr = s_rs[1]; if1.rt_addr = s_rt[1];
        if2.we = s_we[2]; if2.waddr = s_waddr[2][2:0]; if2.wdata = s_wdata[2];
        if2.rs_addr = s_rs[2][2:0]; if2.rt_addr = s_rt[2][2:0];
        if (known) begin
            for (int u = 0; u < 3; u++) begin
                exp_t e;
                e.u = u; e.cyc = cyc;
                e.ready = (cnt[u] >= nr[u]);
                e.rs = model_rd(u, s_rs[u]);
                e.rt = model_rd(u, s_rt[u]);
                q.push_back(e);
            end
        end
        @(posedge clk);
        for (int u = 0; u < 3; u++) begin
            if (s_rst[u]) begin
                cnt[u] = 0;
            end else begin
                if (cnt[u] >= nr[u] && s_we[u] && !(zrf[u] && s_waddr[u] == 5'd0))
                    mem[u][s_waddr[u]] = s_wdata[u] & dmask[u];
                if (cnt[u] < nr[u]) begin
                    cnt[u]++;
                    if (cnt[u] == nr[u])
                        for (int i = 0; i < 32; i++) mem[u][i] = 64'd0;
                end
            end
        end
        known = 1;
        cyc++;
        #1;
    endtask

    task automatic idle_all();
        for (int u = 0; u < 3; u++) begin
            s_rst[u] = 0; s_we[u] = 0; s_waddr[u] = 0; s_wdata[u] = 0;
            s_rs[u] = 0; s_rt[u] = 0;
        end
    endtask

    task automatic rand_stim(int u, int p_we, int p_rst_pm);
        logic [4:0] m;
        m = 5'(nr[u] - 1);
        s_we[u]    = ($urandom % 100) < p_we;
        s_waddr[u] = 5'($urandom) & m;
        s_wdata[u] = {$urandom, $urandom} & dmask[u];
        s_rs[u]    = (($urandom % 4) == 0) ? s_waddr[u] : (5'($urandom) & m);
        s_rt[u]    = (($urandom % 4) == 0) ? s_waddr[u] : (5'($urandom) & m);
        s_rst[u]   = ($urandom % 1000) < p_rst_pm;
    endtask

    task automatic set_all(bit we, logic [4:0] wa, logic [63:0] wd, logic [4:0] ra, logic [4:0] rb);
        for (int u = 0; u < 3; u++) begin
            s_rst[u] = 0; s_we[u] = we;
            s_waddr[u] = wa & 5'(nr[u] - 1);
            s_wdata[u] = wd & dmask[u];
            s_rs[u] = ra & 5'(nr[u] - 1);
            s_rt[u] = rb & 5'(nr[u] - 1);
        end
    endtask

    task automatic reset_all();
        idle_all();
        for (int u = 0; u < 3; u++) s_rst[u] = 1;
        cycle();
        idle_all();
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [63:0] a_rs, a_rt;
            logic        a_rdy;
            e = q.pop_front();
            case (e.u)
                0:       begin a_rdy = if0.ready; a_rs = {32'd0, if0.rs_data}; a_rt = {32'd0, if0.rt_data}; end
                1:       begin a_rdy = if1.ready; a_rs = {32'd0, if1.rs_data}; a_rt = {32'd0, if1.rt_data}; end
                default: begin a_rdy = if2.ready; a_rs = if2.rs_data;          a_rt = if2.rt_data;          end
            endcase
            chk("ready", e.u, e.cyc, {63'd0, a_rdy}, {63'd0, e.ready});
            chk("rs_data", e.u, e.cyc, a_rs, e.rs);
            chk("rt_data", e.u, e.cyc, a_rt, e.rt);
        end
    end

    initial begin
        for (int u = 0; u < 3; u++) begin
            cnt[u] = 0;
            for (int i = 0; i < 32; i++) mem[u][i] = 64'd0;
        end
        reset_all();

        // Clear phase with random traffic; a targeted write to entry 3 at clear cycle 10.
        for (int i = 0; i < 32; i++) begin
            for (int u = 0; u < 3; u++) rand_stim(u, 50, 0);
            if (i == 9) begin
                s_we[0] = 1; s_waddr[0] = 5'd3; s_wdata[0] = 64'hA5A5_A5A5;
                s_we[1] = 1; s_waddr[1] = 5'd3; s_wdata[1] = 64'hA5A5_A5A5;
            end
            cycle();
        end
        set_all(0, 0, 0, 5'd3, 5'd3);
        cycle();

        // Same-cycle bypass on both ports, then read back from storage.
        set_all(1, 5'd7, 64'h0123_4567_1234_5678, 5'd7, 5'd7);
        cycle();
        set_all(0, 5'd7, 0, 5'd7, 5'd7);
        cycle();
        set_all(1, 5'd6, 64'h0123_4567_89AB_CDEF, 5'd6, 5'd7);
        cycle();
        set_all(0, 0, 0, 5'd6, 5'd6);
        cycle();

        // Entry 0: hardwired on units 0 and 2, ordinary on unit 1.
        set_all(1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 5'd0);
        cycle();
        set_all(0, 0, 0, 5'd0, 5'd0);
        cycle();

        // Random traffic including occasional resets while ready.
        for (int i = 0; i < 300; i++) begin
            for (int u = 0; u < 3; u++) rand_stim(u, 60, 8);
            cycle();
        end
        idle_all();
        for (int i = 0; i < 34; i++) cycle();

        // Preload, reset, and confirm the clear zeroes the preloaded entries.
        set_all(1, 5'd5, 64'hDEAD_BEEF_DEAD_BEEF, 5'd5, 5'd31);
        cycle();
        set_all(1, 5'd31, 64'hDEAD_BEEF_DEAD_BEEF, 5'd5, 5'd31);
        cycle();
        set_all(0, 0, 0, 5'd5, 5'd31);
        cycle();
        reset_all();
        for (int i = 0; i < 34; i++) begin
            set_all(0, 0, 0, 5'd5, 5'd31);
            cycle();
        end

        // Reset reasserted part-way through the clear restarts the count.
        reset_all();
        for (int i = 0; i < 20; i++) begin
            for (int u = 0; u < 3; u++) rand_stim(u, 40, 0);
            cycle();
        end
        reset_all();
        for (int i = 0; i < 40; i++) begin
            for (int u = 0; u < 3; u++) rand_stim(u, 50, 0);
            cycle();
        end

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
